// File: rtl/sprite_palette_encoder.sv
// Sprite palette encoder: maps RGB888 pixels onto a fixed 8-entry palette and
// streams the 4-bit indices into sprite memory at consecutive, wrapping addresses.
module sprite_palette_encoder #(
  parameter int DEPTH  = 3648,
  parameter int ADDR_W = 14
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [ADDR_W-1:0] length,
  input  logic [23:0]       pixel_in,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        miss_count
);

  localparam logic [ADDR_W-1:0] DEPTH_W   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] job_len;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_nxt;
  logic [3:0]        index;
  logic              hit;
  logic              accept;
  logic              start_ok;

  assign start_ok    = (state == IDLE) && start;
  assign pixel_ready = (state == RUN) && (count < job_len);
  assign accept      = pixel_valid && pixel_ready;
  assign count_nxt   = count + 1'b1;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  // Exact-match palette lookup; anything else falls back to index 0.
  always_comb begin
    index = 4'd0;
    hit   = 1'b1;
    case (pixel_in)
      24'hFFFFFF: index = 4'd0;
      24'h184110: index = 4'd1;
      24'h60A639: index = 4'd2;
      24'h97C93D: index = 4'd3;
      24'h8FC33C: index = 4'd4;
      24'h49007E: index = 4'd5;
      24'hCDA02B: index = 4'd6;
      24'h7E5125: index = 4'd7;
      default: begin
        index = 4'd0;
        hit   = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; done lasts exactly the single DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (length == '0) ? DONE : RUN;
      RUN:  if (accept && (count_nxt == job_len)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job bookkeeping and the registered one-cycle-latency write port.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_addr   <= '0;
      job_len    <= '0;
      count      <= '0;
      miss_count <= '0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= accept;
      if (start_ok) begin
        cur_addr   <= ADDR_W'(base_address % DEPTH_W);
        job_len    <= (length > DEPTH_W) ? DEPTH_W : length;
        count      <= '0;
        miss_count <= '0;
      end
      if (accept) begin
        wr_address <= cur_addr;
        wr_data    <= index;
        // Wrap at the memory depth rather than at the address-width boundary.
        cur_addr   <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
        count      <= count_nxt;
        if (!hit && (miss_count != 8'hFF)) miss_count <= miss_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_encoder.sv
// Scoreboard bench for sprite_palette_encoder: stimulus pushes expected writes,
// a negedge monitor pops and compares every wr_en strobe.
module tb_sprite_palette_encoder;

  localparam int DEPTH  = 3648;
  localparam int ADDR_W = 14;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_address = '0;
  logic [ADDR_W-1:0] length = '0;
  logic [23:0]       pixel_in = '0;
  logic              pixel_valid = 1'b0;
  logic              pixel_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_address;
  logic [3:0]        wr_data;
  logic              busy;
  logic              done;
  logic [7:0]        miss_count;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [3:0]        d;
    bit                last;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  sprite_palette_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .base_address(base_address),
    .length(length), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .wr_en(wr_en), .wr_address(wr_address),
    .wr_data(wr_data), .busy(busy), .done(done), .miss_count(miss_count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      if (q.size() == 0) begin
        chk("unexpected_wr_en", 32'(wr_address), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_address", 32'(wr_address), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
        chk("done_with_last_write", 32'(done), 32'(e.last));
      end
    end
  end

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic start_job(input int b, input int l);
    start = 1'b1;
    base_address = ADDR_W'(b);
    length = ADDR_W'(l);
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic send_px(input logic [23:0] p, input int a, input int d, input bit last, input int gap);
    int t;
    pixel_valid = 1'b0;
    repeat (gap) begin @(posedge Clk); #1; end
    pixel_in = p;
    pixel_valid = 1'b1;
    t = 0;
    while (!pixel_ready && t < 20) begin @(posedge Clk); #1; t++; end
    if (!pixel_ready) begin
      chk("pixel_ready_timeout", 32'(pixel_ready), 32'd1);
    end else begin
      q.push_back('{a: ADDR_W'(a), d: 4'(d), last: last});
      @(posedge Clk); #1;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic finish_job(input string name, input int d0);
    int t;
    t = 0;
    while (!done && t < 20) begin @(posedge Clk); #1; t++; end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    @(posedge Clk); #1;
    chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_queue_drained"}, 32'(q.size()), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    logic [23:0] v37 [5];
    int g37 [5];
    int e37 [5];
    v37 = '{24'h123456, 24'h000000, 24'hCDA02B, 24'hABCDEF, 24'h49007E};
    g37 = '{1, 2, 0, 3, 1};
    e37 = '{0, 0, 6, 0, 5};

    // Reset values while held in reset.
    #2;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_address", 32'(wr_address), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pixel_ready", 32'(pixel_ready), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // base=100, three matched pixels back-to-back; start taken on first edge out of reset.
    d0 = done_cnt;
    start_job(100, 3);
    chk("t1_busy", 32'(busy), 32'd1);
    send_px(24'h184110, 100, 1, 1'b0, 0);
    send_px(24'h7E5125, 101, 7, 1'b0, 0);
    send_px(24'hFFFFFF, 102, 0, 1'b1, 0);
    finish_job("t1", d0);
    chk("t1_miss", 32'(miss_count), 32'd0);

    // Address wrap at DEPTH-1.
    d0 = done_cnt;
    start_job(3646, 4);
    send_px(24'h60A639, 3646, 2, 1'b0, 0);
    send_px(24'h60A639, 3647, 2, 1'b0, 0);
    send_px(24'h60A639, 0,    2, 1'b0, 0);
    send_px(24'h60A639, 1,    2, 1'b1, 0);
    finish_job("t2", d0);

    // Mixed hits/misses with valid gaps.
    d0 = done_cnt;
    start_job(200, 5);
    for (int i = 0; i < 5; i++) send_px(v37[i], 200 + i, e37[i], (i == 4), g37[i]);
    finish_job("t3", d0);
    chk("t3_miss", 32'(miss_count), 32'd3);
    repeat (3) begin @(posedge Clk); #1; end
    chk("t3_miss_held", 32'(miss_count), 32'd3);

    // Zero-length job.
    d0 = done_cnt;
    start_job(50, 0);
    chk("t4_done_next_cycle", 32'(done), 32'd1);
    chk("t4_ready_low", 32'(pixel_ready), 32'd0);
    @(posedge Clk); #1;
    chk("t4_done_one_cycle", 32'(done), 32'd0);
    chk("t4_ready_low_after", 32'(pixel_ready), 32'd0);
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Base beyond DEPTH folds modulo DEPTH: 3650 -> 2.
    d0 = done_cnt;
    start_job(3650, 2);
    send_px(24'hFFFFFF, 2, 0, 1'b0, 0);
    send_px(24'h8FC33C, 3, 4, 1'b1, 0);
    finish_job("t5", d0);

    // 300 unmatched pixels: miss_count saturates.
    d0 = done_cnt;
    start_job(0, 300);
    for (int i = 0; i < 300; i++) send_px(24'h010203, i, 0, (i == 299), 0);
    finish_job("t6", d0);
    chk("t6_miss_sat", 32'(miss_count), 32'd255);

    // Start while busy is ignored; reset mid-job aborts.
    d0 = done_cnt;
    start_job(500, 10);
    start_job(0, 0);
    chk("t7_busy_after_start", 32'(busy), 32'd1);
    send_px(24'h97C93D, 500, 3, 1'b0, 0);
    send_px(24'h010101, 501, 0, 1'b0, 0);
    @(negedge Clk); #1;
    Reset_n = 1'b0;
    #1;
    chk("t7_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t7_rst_wr_address", 32'(wr_address), 32'd0);
    chk("t7_rst_wr_data", 32'(wr_data), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_ready", 32'(pixel_ready), 32'd0);
    chk("t7_rst_miss", 32'(miss_count), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    pixel_in = 24'h60A639;
    pixel_valid = 1'b1;
    repeat (5) begin @(posedge Clk); #1; end
    chk("t7_no_resume_ready", 32'(pixel_ready), 32'd0);
    chk("t7_no_resume_busy", 32'(busy), 32'd0);
    pixel_valid = 1'b0;
    chk("t7_done_pulses", 32'(done_cnt - d0), 32'd0);
    chk("t7_queue_drained", 32'(q.size()), 32'd0);

    repeat (2) begin @(posedge Clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
